// File: rtl/mosi_bridge_pkg.sv
// Shared types and constants for the MOSI-to-native bridge: FSM states,
// command-beat field layout, direction codes and error codes.
package mosi_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_WRITE = 3'd2,
        ST_READ  = 3'd3,
        ST_EXCP  = 3'd4
    } state_e;

    localparam logic [1:0] DIR_WR = 2'b01;
    localparam logic [1:0] DIR_RD = 2'b10;

    localparam int CMD_DIR_LSB  = 0;
    localparam int CMD_LEN_LSB  = 2;
    localparam int CMD_ADDR_LSB = 10;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_LEN     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/mosi_bridge_fifo.sv
// Synchronous FIFO of native words with occupancy count and flush. A push
// into a full FIFO is taken only when a pop happens in the same cycle.
module mosi_bridge_fifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    import mosi_bridge_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push_s, do_pop_s;

    // Pointer and occupancy next-state
    always_comb begin
        do_pop_s  = pop_i && (count_q != (AW+1)'(0));
        do_push_s = push_i && ((count_q != (AW+1)'(DEPTH)) || do_pop_s);
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        if (flush_i) begin
            wptr_d  = AW'(0);
            rptr_d  = AW'(0);
            count_d = (AW+1)'(0);
        end else begin
            wptr_d  = do_push_s ? (wptr_q + AW'(1)) : wptr_q;
            rptr_d  = do_pop_s  ? (rptr_q + AW'(1)) : rptr_q;
            count_d = count_q + (AW+1)'(do_push_s) - (AW+1)'(do_pop_s);
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= AW'(0);
            rptr_q  <= AW'(0);
            count_q <= (AW+1)'(0);
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage array
    always_ff @(posedge clk) begin
        if (do_push_s && !flush_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign empty_o = (count_q == (AW+1)'(0));
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;

endmodule

// File: rtl/mosi_native_bridge.sv
// MOSI command/burst stream to DDR-native command and data bridge with read credits.
// Optional no-progress watchdog is built when MOSI_BRIDGE_TIMEOUT_EN is defined.
module mosi_native_bridge #(
    parameter int MOSI_W      = 256,
    parameter int NAT_W       = 512,
    parameter int ADDR_W      = 28,
    parameter int MAX_LEN     = 64,
    parameter int FIFO_DEPTH  = 32,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_i,
    input  logic                 mosi_valid_i,
    input  logic [MOSI_W-1:0]    mosi_data_i,
    output logic                 mosi_ready_o,
    output logic                 miso_valid_o,
    output logic [MOSI_W-1:0]    miso_data_o,
    input  logic                 miso_ready_i,
    output logic                 ncmd_valid_o,
    input  logic                 ncmd_ready_i,
    output logic                 ncmd_we_o,
    output logic [ADDR_W-1:0]    ncmd_addr_o,
    output logic                 wdata_valid_o,
    input  logic                 wdata_ready_i,
    output logic [NAT_W-1:0]     wdata_data_o,
    output logic [NAT_W/8-1:0]   wdata_we_o,
    input  logic                 rdata_valid_i,
    input  logic [NAT_W-1:0]     rdata_data_i,
    output logic                 rdata_ready_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 irq_o,
    output logic [1:0]           err_o
);
    import mosi_bridge_pkg::*;

    localparam int RATIO = NAT_W / MOSI_W;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int CW    = $clog2(FIFO_DEPTH);
    localparam int TO_W  = $clog2(TIMEOUT_CYC) + 1;

    state_e             state_q, state_d;
    logic [1:0]         dir_q, dir_d, err_q, err_d;
    logic [7:0]         len_q, len_d, cmds_q, cmds_d, beats_rx_q, beats_rx_d;
    logic [7:0]         words_q, words_d, beats_tx_q, beats_tx_d, nwords_s;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [CW:0]        outst_q, outst_d;
    logic [NAT_W-1:0]   pack_q, pack_d;
    logic [IDX_W-1:0]   pidx_q, pidx_d, uidx_q, uidx_d;
    logic               pfull_q, pfull_d, irq_q, irq_d, done_q, done_d, run_q;
    logic               mosi_ready_s, ncmd_valid_s, wdata_valid_s, miso_valid_s, credit_ok_s;
    logic               mosi_hs_s, ncmd_hs_s, wdata_hs_s, rdata_hs_s, miso_hs_s, any_hs_s;
    logic               fifo_push_s, fifo_pop_s, fifo_empty_s, fifo_full_s;
    logic [NAT_W-1:0]   fifo_wdata_s, fifo_head_s;
    logic [CW:0]        fifo_count_s;
`ifdef MOSI_BRIDGE_TIMEOUT_EN
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
`endif

    mosi_bridge_fifo #(.WIDTH(NAT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (clr_i),
        .push_i  (fifo_push_s),
        .wdata_i (fifo_wdata_s),
        .pop_i   (fifo_pop_s),
        .rdata_o (fifo_head_s),
        .empty_o (fifo_empty_s),
        .full_o  (fifo_full_s),
        .count_o (fifo_count_s)
    );

    assign nwords_s = len_q / 8'(RATIO);
    // Reads in flight plus words already buffered must never exceed FIFO space.
    assign credit_ok_s = ({1'b0, outst_q} + {1'b0, fifo_count_s}) < (CW+2)'(FIFO_DEPTH);

    // Handshake-side valid/ready generation
    always_comb begin
        mosi_ready_s = 1'b0;
        case (state_q)
            ST_IDLE:  mosi_ready_s = run_q && !irq_q;
            ST_WRITE: mosi_ready_s = !pfull_q && (beats_rx_q < len_q);
            default:  mosi_ready_s = 1'b0;
        endcase
        ncmd_valid_s  = (cmds_q < nwords_s) &&
                        ((state_q == ST_WRITE) || ((state_q == ST_READ) && credit_ok_s));
        wdata_valid_s = (state_q == ST_WRITE) && !fifo_empty_s;
        miso_valid_s  = (state_q == ST_READ) && !fifo_empty_s;
        mosi_hs_s     = mosi_valid_i && mosi_ready_s;
        ncmd_hs_s     = ncmd_valid_s && ncmd_ready_i;
        wdata_hs_s    = wdata_valid_s && wdata_ready_i;
        rdata_hs_s    = rdata_valid_i && (state_q == ST_READ);
        miso_hs_s     = miso_valid_s && miso_ready_i;
        any_hs_s      = mosi_hs_s || ncmd_hs_s || wdata_hs_s || rdata_hs_s || miso_hs_s;
    end

    // FSM next-state, counters, packer/unpacker and FIFO control
    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        len_d        = len_q;
        addr_d       = addr_q;
        cmds_d       = cmds_q;
        beats_rx_d   = beats_rx_q;
        words_d      = words_q;
        beats_tx_d   = beats_tx_q;
        outst_d      = outst_q;
        pack_d       = pack_q;
        pidx_d       = pidx_q;
        pfull_d      = pfull_q;
        uidx_d       = uidx_q;
        irq_d        = irq_q;
        err_d        = err_q;
        done_d       = 1'b0;
        fifo_push_s  = 1'b0;
        fifo_pop_s   = 1'b0;
        fifo_wdata_s = rdata_data_i;
`ifdef MOSI_BRIDGE_TIMEOUT_EN
        to_cnt_d     = to_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (mosi_hs_s) begin
                    dir_d      = mosi_data_i[CMD_DIR_LSB +: 2];
                    len_d      = mosi_data_i[CMD_LEN_LSB +: 8];
                    addr_d     = mosi_data_i[CMD_ADDR_LSB +: ADDR_W];
                    cmds_d     = 8'd0;
                    beats_rx_d = 8'd0;
                    words_d    = 8'd0;
                    beats_tx_d = 8'd0;
                    outst_d    = (CW+1)'(0);
                    pidx_d     = IDX_W'(0);
                    pfull_d    = 1'b0;
                    uidx_d     = IDX_W'(0);
                    state_d    = ST_CMD;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_CMD: begin
                if ((len_q == 8'd0) || (len_q > 8'(MAX_LEN)) ||
                    ((len_q % 8'(RATIO)) != 8'd0) ||
                    ((dir_q != DIR_WR) && (dir_q != DIR_RD))) begin
                    state_d = ST_EXCP;
                    irq_d   = 1'b1;
                    err_d   = ERR_LEN;
                end else if (dir_q == DIR_WR) begin
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_WRITE: begin
                fifo_wdata_s = pack_q;
                if (mosi_hs_s) begin
                    pack_d[pidx_q*MOSI_W +: MOSI_W] = mosi_data_i;
                    beats_rx_d = beats_rx_q + 8'd1;
                    if (pidx_q == IDX_W'(RATIO-1)) begin
                        pidx_d  = IDX_W'(0);
                        pfull_d = 1'b1;
                    end else begin
                        pidx_d  = pidx_q + IDX_W'(1);
                    end
                end else if (pfull_q && !fifo_full_s) begin
                    fifo_push_s = 1'b1;
                    pfull_d     = 1'b0;
                end else begin
                    pfull_d     = pfull_q;
                end
                fifo_pop_s = wdata_hs_s;
                words_d    = wdata_hs_s ? (words_q + 8'd1) : words_q;
                if ((words_q == nwords_s) && (cmds_q == nwords_s)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_READ: begin
                fifo_push_s = rdata_hs_s;
                if (miso_hs_s) begin
                    beats_tx_d = beats_tx_q + 8'd1;
                    if (uidx_q == IDX_W'(RATIO-1)) begin
                        uidx_d     = IDX_W'(0);
                        fifo_pop_s = 1'b1;
                    end else begin
                        uidx_d     = uidx_q + IDX_W'(1);
                    end
                end else begin
                    uidx_d = uidx_q;
                end
                if (beats_tx_q == len_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_EXCP: state_d = ST_EXCP;
            default: state_d = ST_IDLE;
        endcase

        if (ncmd_hs_s) begin
            addr_d = addr_q + ADDR_W'(NAT_W/8);
            cmds_d = cmds_q + 8'd1;
        end else begin
            addr_d = addr_d;
        end

        case ({ncmd_hs_s && (state_q == ST_READ), rdata_hs_s && (outst_q != (CW+1)'(0))})
            2'b10:   outst_d = outst_q + (CW+1)'(1);
            2'b01:   outst_d = outst_q - (CW+1)'(1);
            default: outst_d = outst_d;
        endcase

`ifdef MOSI_BRIDGE_TIMEOUT_EN
        if ((state_q == ST_WRITE) || (state_q == ST_READ)) begin
            if (any_hs_s) begin
                to_cnt_d = TO_W'(0);
            end else if (to_cnt_q == TO_W'(TIMEOUT_CYC-1)) begin
                to_cnt_d = TO_W'(0);
                state_d  = ST_EXCP;
                irq_d    = 1'b1;
                err_d    = ERR_TIMEOUT;
                done_d   = 1'b0;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end else begin
            to_cnt_d = TO_W'(0);
        end
`endif

        if (clr_i) begin
            state_d     = ST_IDLE;
            cmds_d      = 8'd0;
            beats_rx_d  = 8'd0;
            words_d     = 8'd0;
            beats_tx_d  = 8'd0;
            outst_d     = (CW+1)'(0);
            pidx_d      = IDX_W'(0);
            pfull_d     = 1'b0;
            uidx_d      = IDX_W'(0);
            irq_d       = 1'b0;
            err_d       = ERR_NONE;
            done_d      = 1'b0;
            fifo_push_s = 1'b0;
            fifo_pop_s  = 1'b0;
        end else begin
            state_d     = state_d;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            dir_q      <= 2'b00;
            len_q      <= 8'd0;
            addr_q     <= ADDR_W'(0);
            cmds_q     <= 8'd0;
            beats_rx_q <= 8'd0;
            words_q    <= 8'd0;
            beats_tx_q <= 8'd0;
            outst_q    <= (CW+1)'(0);
            pack_q     <= NAT_W'(0);
            pidx_q     <= IDX_W'(0);
            pfull_q    <= 1'b0;
            uidx_q     <= IDX_W'(0);
            irq_q      <= 1'b0;
            err_q      <= ERR_NONE;
            done_q     <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            cmds_q     <= cmds_d;
            beats_rx_q <= beats_rx_d;
            words_q    <= words_d;
            beats_tx_q <= beats_tx_d;
            outst_q    <= outst_d;
            pack_q     <= pack_d;
            pidx_q     <= pidx_d;
            pfull_q    <= pfull_d;
            uidx_q     <= uidx_d;
            irq_q      <= irq_d;
            err_q      <= err_d;
            done_q     <= done_d;
            run_q      <= 1'b1;
        end
    end

`ifdef MOSI_BRIDGE_TIMEOUT_EN
    // Watchdog counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= TO_W'(0);
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`endif

    // Data buses are zeroed while their valid is low so reset shows all-zero outputs.
    assign mosi_ready_o  = mosi_ready_s;
    assign miso_valid_o  = miso_valid_s;
    assign miso_data_o   = miso_valid_s ? fifo_head_s[uidx_q*MOSI_W +: MOSI_W] : MOSI_W'(0);
    assign ncmd_valid_o  = ncmd_valid_s;
    assign ncmd_we_o     = ncmd_valid_s && (state_q == ST_WRITE);
    assign ncmd_addr_o   = addr_q;
    assign wdata_valid_o = wdata_valid_s;
    assign wdata_data_o  = wdata_valid_s ? fifo_head_s : NAT_W'(0);
    assign wdata_we_o    = {(NAT_W/8){wdata_valid_s}};
    assign rdata_ready_o = (state_q == ST_READ);
    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = done_q;
    assign irq_o         = irq_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_mosi_native_bridge.sv
// Scoreboard bench for mosi_native_bridge: native commands, write words and
// MISO beats are predicted into queues and checked as the DUT produces them.
module tb_mosi_native_bridge;

    localparam int MOSI_W      = 256;
    localparam int NAT_W       = 512;
    localparam int ADDR_W      = 28;
    localparam int MAX_LEN     = 64;
    localparam int FIFO_DEPTH  = 4;
    localparam int TIMEOUT_CYC = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n = 1'b0, clr_i = 1'b0;
    logic                mosi_valid_i = 1'b0;
    logic [MOSI_W-1:0]   mosi_data_i = '0;
    logic                miso_ready_i = 1'b1, ncmd_ready_i = 1'b1, wdata_ready_i = 1'b1;
    logic                rdata_valid_i = 1'b0;
    logic [NAT_W-1:0]    rdata_data_i = '0;
    logic                mosi_ready_o, miso_valid_o, ncmd_valid_o, ncmd_we_o, wdata_valid_o;
    logic [MOSI_W-1:0]   miso_data_o;
    logic [ADDR_W-1:0]   ncmd_addr_o;
    logic [NAT_W-1:0]    wdata_data_o;
    logic [NAT_W/8-1:0]  wdata_we_o;
    logic                rdata_ready_o, busy_o, done_o, irq_o;
    logic [1:0]          err_o;

    mosi_native_bridge #(
        .MOSI_W(MOSI_W), .NAT_W(NAT_W), .ADDR_W(ADDR_W), .MAX_LEN(MAX_LEN),
        .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr_i(clr_i),
        .mosi_valid_i(mosi_valid_i), .mosi_data_i(mosi_data_i), .mosi_ready_o(mosi_ready_o),
        .miso_valid_o(miso_valid_o), .miso_data_o(miso_data_o), .miso_ready_i(miso_ready_i),
        .ncmd_valid_o(ncmd_valid_o), .ncmd_ready_i(ncmd_ready_i), .ncmd_we_o(ncmd_we_o),
        .ncmd_addr_o(ncmd_addr_o),
        .wdata_valid_o(wdata_valid_o), .wdata_ready_i(wdata_ready_i), .wdata_data_o(wdata_data_o),
        .wdata_we_o(wdata_we_o),
        .rdata_valid_i(rdata_valid_i), .rdata_data_i(rdata_data_i), .rdata_ready_o(rdata_ready_o),
        .busy_o(busy_o), .done_o(done_o), .irq_o(irq_o), .err_o(err_o)
    );

    typedef struct packed { logic we; logic [ADDR_W-1:0] addr; } cmd_t;
    typedef struct packed { logic [31:0] due; logic [NAT_W-1:0] data; } rd_t;

    int total = 0, bad = 0, cyc = 0, ncmd_rd_cnt = 0, miso_cnt = 0;
    cmd_t              exp_cmd_q[$];
    logic [NAT_W-1:0]  exp_wd_q[$];
    logic [MOSI_W-1:0] exp_miso_q[$];
    rd_t               rd_pend_q[$];
    logic              rd_hs_seen = 1'b0;

    function automatic logic [NAT_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        logic [NAT_W-1:0] w;
        for (int i = 0; i < NAT_W/32; i++) w[i*32 +: 32] = {4'h0, a} ^ (32'h9E37_79B9 * (i + 1));
        return w;
    endfunction

    function automatic logic [MOSI_W-1:0] rand_beat();
        logic [MOSI_W-1:0] r;
        for (int k = 0; k < MOSI_W/32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [MOSI_W-1:0] mk_cmd(input logic [1:0] dir, input logic [7:0] len,
                                                 input logic [ADDR_W-1:0] a);
        logic [MOSI_W-1:0] c;
        c = '0;
        c[1:0] = dir;
        c[9:2] = len;
        c[10 +: ADDR_W] = a;
        return c;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitors: pop and compare every completed handshake
    always @(negedge clk) begin : mon
        cmd_t c;
        logic [NAT_W-1:0] w;
        logic [MOSI_W-1:0] b;
        if (rst_n) begin
            if (ncmd_valid_o && ncmd_ready_i) begin
                total++;
                if (exp_cmd_q.size() == 0) begin
                    bad++;
                    $display("FAIL ncmd_unexpected got we=%0b addr=%h required none", ncmd_we_o, ncmd_addr_o);
                end else begin
                    c = exp_cmd_q.pop_front();
                    if ({ncmd_we_o, ncmd_addr_o} !== c) begin
                        bad++;
                        $display("FAIL ncmd got we=%0b addr=%h required we=%0b addr=%h",
                                 ncmd_we_o, ncmd_addr_o, c.we, c.addr);
                    end
                end
                if (!ncmd_we_o) begin
                    rd_pend_q.push_back({32'(cyc + 10), mem_word(ncmd_addr_o)});
                    ncmd_rd_cnt++;
                end
            end
            if (wdata_valid_o && wdata_ready_i) begin
                total++;
                if (exp_wd_q.size() == 0) begin
                    bad++;
                    $display("FAIL wdata_unexpected got=%h required none", wdata_data_o[63:0]);
                end else begin
                    w = exp_wd_q.pop_front();
                    if (wdata_data_o !== w || wdata_we_o !== {(NAT_W/8){1'b1}}) begin
                        bad++;
                        $display("FAIL wdata got=%h required=%h", wdata_data_o, w);
                    end
                end
            end
            if (miso_valid_o && miso_ready_i) begin
                total++;
                miso_cnt++;
                if (exp_miso_q.size() == 0) begin
                    bad++;
                    $display("FAIL miso_unexpected got=%h required none", miso_data_o[63:0]);
                end else begin
                    b = exp_miso_q.pop_front();
                    if (miso_data_o !== b) begin
                        bad++;
                        $display("FAIL miso got=%h required=%h", miso_data_o, b);
                    end
                end
            end
        end
        rd_hs_seen = rst_n && rdata_valid_i && rdata_ready_o;
    end

    // Native read responder with fixed latency
    always begin
        @(posedge clk);
        #1;
        if (rd_hs_seen && rd_pend_q.size() > 0) rd_pend_q.delete(0);
        if (rd_pend_q.size() > 0 && rd_pend_q[0].due <= 32'(cyc)) begin
            rdata_valid_i = 1'b1;
            rdata_data_i  = rd_pend_q[0].data;
        end else begin
            rdata_valid_i = 1'b0;
            rdata_data_i  = '0;
        end
    end

    task automatic send_beat(input logic [MOSI_W-1:0] d);
        int n;
        @(posedge clk); #1;
        mosi_valid_i = 1'b1;
        mosi_data_i  = d;
        n = 0;
        @(negedge clk);
        while (!mosi_ready_o && n < 300) begin n++; @(negedge clk); end
        total++;
        if (mosi_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL mosi_accept got ready=%0b required 1 within 300 cycles", mosi_ready_o);
        end
        @(posedge clk); #1;
        mosi_valid_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!done_o && n < budget) begin n++; @(negedge clk); end
        total++;
        if (done_o !== 1'b1) begin
            bad++;
            $display("FAIL done_pulse got=%0b required 1 within %0d cycles", done_o, budget);
        end
        total++;
        if (busy_o !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_done got busy=%0b required 0", busy_o);
        end
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1; clr_i = 1'b1;
        @(posedge clk); #1; clr_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string name);
        logic any_out;
        any_out = mosi_ready_o | miso_valid_o | (|miso_data_o) | ncmd_valid_o | ncmd_we_o |
                  (|ncmd_addr_o) | wdata_valid_o | (|wdata_data_o) | (|wdata_we_o) |
                  rdata_ready_o | busy_o | done_o | irq_o | (|err_o);
        total++;
        if (any_out !== 1'b0) begin
            bad++;
            $display("FAIL %s got rdy=%0b busy=%0b ncmd=%0b wd=%0b irq=%0b err=%0b required all 0",
                     name, mosi_ready_o, busy_o, ncmd_valid_o, wdata_valid_o, irq_o, err_o);
        end
    endtask

    task automatic test_reset();
        #12;
        check_outputs_zero("reset_outputs");
        #11 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (mosi_ready_o !== 1'b1 || busy_o !== 1'b0 || irq_o !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset got rdy=%0b busy=%0b irq=%0b required 1 0 0",
                     mosi_ready_o, busy_o, irq_o);
        end
    endtask

    task automatic test_write(input logic [ADDR_W-1:0] a, input int len);
        logic [MOSI_W-1:0] beats[$];
        for (int i = 0; i < len; i++) beats.push_back(rand_beat());
        for (int i = 0; i < len/2; i++) begin
            exp_cmd_q.push_back({1'b1, a + ADDR_W'(i*64)});
            exp_wd_q.push_back({beats[2*i+1], beats[2*i]});
        end
        send_beat(mk_cmd(2'b01, 8'(len), a));
        foreach (beats[i]) send_beat(beats[i]);
        wait_done(400);
        total++;
        if (exp_cmd_q.size() != 0 || exp_wd_q.size() != 0) begin
            bad++;
            $display("FAIL write_drain got cmd_left=%0d wd_left=%0d required 0 0",
                     exp_cmd_q.size(), exp_wd_q.size());
        end
    endtask

    task automatic test_read(input logic [ADDR_W-1:0] a, input int len);
        logic [NAT_W-1:0] w;
        int start;
        start = miso_cnt;
        for (int i = 0; i < len/2; i++) begin
            exp_cmd_q.push_back({1'b0, a + ADDR_W'(i*64)});
            w = mem_word(a + ADDR_W'(i*64));
            exp_miso_q.push_back(w[MOSI_W-1:0]);
            exp_miso_q.push_back(w[NAT_W-1:MOSI_W]);
        end
        send_beat(mk_cmd(2'b10, 8'(len), a));
        wait_done(600);
        total++;
        if (miso_cnt - start != len || exp_cmd_q.size() != 0) begin
            bad++;
            $display("FAIL read_count got beats=%0d cmd_left=%0d required %0d 0",
                     miso_cnt - start, exp_cmd_q.size(), len);
        end
    endtask

    task automatic test_bad_len();
        logic [1:0] dirs[4];
        logic [7:0] lens[4];
        dirs = '{2'b01, 2'b01, 2'b10, 2'b11};
        lens = '{8'd3, 8'd0, 8'd66, 8'd4};
        for (int t = 0; t < 4; t++) begin
            send_beat(mk_cmd(dirs[t], lens[t], 28'h0000_200));
            repeat (3) @(negedge clk);
            total++;
            if (irq_o !== 1'b1 || err_o !== 2'b01 || mosi_ready_o !== 1'b0 || busy_o !== 1'b1) begin
                bad++;
                $display("FAIL bad_len_%0d got irq=%0b err=%b rdy=%0b busy=%0b required 1 01 0 1",
                         t, irq_o, err_o, mosi_ready_o, busy_o);
            end
            pulse_clr();
            total++;
            if (irq_o !== 1'b0 || err_o !== 2'b00 || busy_o !== 1'b0 || mosi_ready_o !== 1'b1) begin
                bad++;
                $display("FAIL clr_%0d got irq=%0b err=%b busy=%0b rdy=%0b required 0 00 0 1",
                         t, irq_o, err_o, busy_o, mosi_ready_o);
            end
        end
    endtask

    task automatic test_credit();
        logic [NAT_W-1:0] w;
        logic [MOSI_W-1:0] hold;
        int start;
        start = ncmd_rd_cnt;
        for (int i = 0; i < 32; i++) begin
            exp_cmd_q.push_back({1'b0, 28'h0010_000 + ADDR_W'(i*64)});
            w = mem_word(28'h0010_000 + ADDR_W'(i*64));
            exp_miso_q.push_back(w[MOSI_W-1:0]);
            exp_miso_q.push_back(w[NAT_W-1:MOSI_W]);
        end
        miso_ready_i = 1'b0;
        send_beat(mk_cmd(2'b10, 8'd64, 28'h0010_000));
        repeat (80) @(negedge clk);
        total++;
        if (ncmd_rd_cnt - start != FIFO_DEPTH) begin
            bad++;
            $display("FAIL credit_limit got cmds=%0d required %0d", ncmd_rd_cnt - start, FIFO_DEPTH);
        end
        hold = miso_data_o;
        total++;
        if (miso_valid_o !== 1'b1) begin
            bad++;
            $display("FAIL miso_pending got valid=%0b required 1", miso_valid_o);
        end
        repeat (5) @(negedge clk);
        total++;
        if (miso_data_o !== hold) begin
            bad++;
            $display("FAIL miso_stable got=%h required=%h", miso_data_o[63:0], hold[63:0]);
        end
        @(posedge clk); #1; miso_ready_i = 1'b1;
        wait_done(3000);
        total++;
        if (ncmd_rd_cnt - start != 32 || exp_miso_q.size() != 0) begin
            bad++;
            $display("FAIL credit_drain got cmds=%0d miso_left=%0d required 32 0",
                     ncmd_rd_cnt - start, exp_miso_q.size());
        end
    endtask

    task automatic test_stall();
        exp_cmd_q.push_back({1'b1, 28'h0000_500});
        wdata_ready_i = 1'b0;
        send_beat(mk_cmd(2'b01, 8'd2, 28'h0000_500));
        send_beat(rand_beat());
        send_beat(rand_beat());
        repeat (40) @(negedge clk);
        total++;
`ifdef MOSI_BRIDGE_TIMEOUT_EN
        if (err_o !== 2'b10 || irq_o !== 1'b1 || busy_o !== 1'b1 || wdata_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL timeout got err=%b irq=%0b busy=%0b wd=%0b required 10 1 1 0",
                     err_o, irq_o, busy_o, wdata_valid_o);
        end
`else
        if (err_o !== 2'b00 || irq_o !== 1'b0 || busy_o !== 1'b1 || wdata_valid_o !== 1'b1) begin
            bad++;
            $display("FAIL stall_hold got err=%b irq=%0b busy=%0b wd=%0b required 00 0 1 1",
                     err_o, irq_o, busy_o, wdata_valid_o);
        end
`endif
        pulse_clr();
        wdata_ready_i = 1'b1;
        total++;
        if (busy_o !== 1'b0 || wdata_valid_o !== 1'b0 || exp_cmd_q.size() != 0) begin
            bad++;
            $display("FAIL stall_clr got busy=%0b wd=%0b cmd_left=%0d required 0 0 0",
                     busy_o, wdata_valid_o, exp_cmd_q.size());
        end
    endtask

    task automatic test_reset_mid_write();
        exp_cmd_q.push_back({1'b1, 28'h0000_300});
        exp_cmd_q.push_back({1'b1, 28'h0000_340});
        send_beat(mk_cmd(2'b01, 8'd4, 28'h0000_300));
        send_beat(rand_beat());
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("reset_mid_write");
        exp_cmd_q.delete();
        exp_wd_q.delete();
        rd_pend_q.delete();
        #13 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        test_write(28'h0000_400, 4);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got no finish required finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write(28'h0000_100, 4);
        test_read(28'h0002_000, 8);
        test_bad_len();
        test_credit();
        test_stall();
        test_reset_mid_write();
        test_write(28'hFFF_FFC0, 4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
